// File: rtl/spi_pframe_pkg.sv
// Shared types and helpers for the parametrised SPI frame slave: FSM state encoding,
// command codes and the odd-parity helper used by the SPI_SLAVE_PARITY_EN build.
package spi_pframe_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadDataRx,
    StReadDataWait,
    StReadDataTx
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Widest vector the parity helper accepts; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned ParMaxW = 64;

  // Bit that makes the total count of ones (vector plus this bit) odd.
  function automatic logic odd_parity(input logic [ParMaxW-1:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/spi_shift_ctr.sv
// Loadable down-counter paired with an MSB-first shift register; the frame slave uses one
// instance for frame capture and one for read-data serialisation.
module spi_shift_ctr #(
  parameter int unsigned Width = 10,
  parameter int unsigned CntW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_clr,
  input  logic             cnt_load,
  input  logic [CntW-1:0]  cnt_val,
  input  logic             cnt_dec,
  input  logic             data_load,
  input  logic [Width-1:0] data_val,
  input  logic             data_shift,
  input  logic             din,
  output logic [Width-1:0] data,
  output logic [CntW-1:0]  cnt
);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_load) begin
      cnt_d = cnt_val;
    end else if (cnt_dec) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    data_d = data_q;
    if (data_load) begin
      data_d = data_val;
    end else if (data_shift) begin
      data_d = {data_q[Width-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign data = data_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/spi_slave_pframe.sv
// SPI frame slave for the single-port-RAM subsystem: 2-bit command + DATA_W payload frames,
// read-data handshake and abort detection. Define SPI_SLAVE_PARITY_EN for odd-parity framing.
module spi_slave_pframe
  import spi_pframe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  localparam int unsigned FRAME_W = DATA_W + 2,
  localparam int unsigned CNT_W = $clog2(DATA_W + 4)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               busy,
  output logic               frame_err
);

`ifdef SPI_SLAVE_PARITY_EN
  localparam int unsigned ParW = 1;
`else
  localparam int unsigned ParW = 0;
`endif
  localparam int unsigned RxLen = FRAME_W + ParW;
  localparam int unsigned TxW   = DATA_W + ParW;

  state_e cs_q, cs_d;
  logic   sel_q, sel_d;
  logic   seen_q, seen_d;
  logic   rx_valid_q, rx_valid_d;
  logic   frame_err_q, frame_err_d;

  logic               ctr_clr;
  logic               rx_cnt_load, rx_cnt_dec, rx_shift;
  logic               tx_load, tx_shift;
  logic [FRAME_W-1:0] rx_sr;
  logic [CNT_W-1:0]   rx_cnt, tx_cnt;
  logic [TxW-1:0]     tx_sr, tx_load_val;
  logic               rx_busy, rx_last, tx_busy, tx_last;
  logic [1:0]         rx_cmd;
  logic               rx_shift_ok, rx_par_ok, rx_sel_ok;
  logic               unused_tx_sr;

  assign rx_busy = (rx_cnt != '0);
  assign rx_last = (rx_cnt == CNT_W'(1));
  assign tx_busy = (tx_cnt != '0);
  assign tx_last = (tx_cnt == CNT_W'(1));

`ifdef SPI_SLAVE_PARITY_EN
  // Final edge carries the parity bit, which is checked but never shifted into rx_data.
  assign rx_shift_ok = !rx_last;
  assign rx_cmd      = rx_sr[FRAME_W-1 -: 2];
  assign rx_par_ok   = (mosi == odd_parity(ParMaxW'(rx_sr)));
  assign tx_load_val = {tx_data, odd_parity(ParMaxW'(tx_data))};
`else
  // Checked on the last-bit edge, before the final shift has moved cmd into the top bits.
  assign rx_shift_ok = 1'b1;
  assign rx_cmd      = rx_sr[FRAME_W-2 -: 2];
  assign rx_par_ok   = 1'b1;
  assign tx_load_val = tx_data;
`endif

  assign rx_sel_ok = (((rx_cmd == CMD_RD_ADDR) || (rx_cmd == CMD_RD_DATA)) == sel_q);

  always_comb begin
    cs_d        = cs_q;
    sel_d       = sel_q;
    seen_d      = seen_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    ctr_clr     = 1'b0;
    rx_cnt_load = 1'b0;
    rx_cnt_dec  = 1'b0;
    rx_shift    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    if (ss_n && (cs_q != StIdle)) begin
      cs_d    = StIdle;
      ctr_clr = 1'b1;
      unique case (cs_q)
        StChkCmd, StReadDataWait:         frame_err_d = 1'b1;
        StWrite, StReadAdd, StReadDataRx: frame_err_d = rx_busy;
        StReadDataTx:                     frame_err_d = tx_busy;
        default:                          frame_err_d = 1'b0;
      endcase
    end else begin
      unique case (cs_q)
        StIdle: begin
          if (!ss_n) cs_d = StChkCmd;
        end
        StChkCmd: begin
          sel_d       = mosi;
          rx_cnt_load = 1'b1;
          if (!mosi) begin
            cs_d = StWrite;
          end else if (seen_q) begin
            cs_d = StReadDataRx;
          end else begin
            cs_d = StReadAdd;
          end
        end
        StWrite, StReadAdd, StReadDataRx: begin
          if (rx_busy) begin
            rx_cnt_dec = 1'b1;
            rx_shift   = rx_shift_ok;
            if (rx_last) begin
              if (rx_sel_ok && rx_par_ok) begin
                rx_valid_d = 1'b1;
                if (cs_q == StReadAdd) seen_d = 1'b1;
                if (cs_q == StReadDataRx) cs_d = StReadDataWait;
              end else begin
                frame_err_d = 1'b1;
              end
            end
          end
        end
        StReadDataWait: begin
          if (tx_valid && tx_ready) begin
            tx_load = 1'b1;
            cs_d    = StReadDataTx;
          end
        end
        StReadDataTx: begin
          if (tx_busy) begin
            tx_shift = 1'b1;
            if (tx_last) seen_d = 1'b0;
          end
        end
        default: cs_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q        <= StIdle;
      sel_q       <= 1'b0;
      seen_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cs_q        <= cs_d;
      sel_q       <= sel_d;
      seen_q      <= seen_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  spi_shift_ctr #(
    .Width (FRAME_W),
    .CntW  (CNT_W)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .cnt_clr    (ctr_clr),
    .cnt_load   (rx_cnt_load),
    .cnt_val    (CNT_W'(RxLen)),
    .cnt_dec    (rx_cnt_dec),
    .data_load  (1'b0),
    .data_val   ('0),
    .data_shift (rx_shift),
    .din        (mosi),
    .data       (rx_sr),
    .cnt        (rx_cnt)
  );

  spi_shift_ctr #(
    .Width (TxW),
    .CntW  (CNT_W)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .cnt_clr    (ctr_clr),
    .cnt_load   (tx_load),
    .cnt_val    (CNT_W'(TxW)),
    .cnt_dec    (tx_shift),
    .data_load  (tx_load),
    .data_val   (tx_load_val),
    .data_shift (tx_shift),
    .din        (1'b0),
    .data       (tx_sr),
    .cnt        (tx_cnt)
  );

  assign unused_tx_sr = ^tx_sr[TxW-2:0];

  assign miso      = (cs_q == StReadDataTx) && tx_busy && tx_sr[TxW-1];
  assign rx_data   = rx_sr;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign tx_ready  = (cs_q == StReadDataWait) && !ss_n;
  assign busy      = (cs_q != StIdle);

endmodule

// File: tb/tb_spi_slave_pframe.sv
// Scoreboard bench for spi_slave_pframe: the driver predicts each frame's outcome from the
// command rules and queues it; a negedge monitor checks pulses and the miso stream.
module tb_spi_slave_pframe;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int RX_LEN = FRAME_W + PAR;
  localparam int TX_LEN = DATA_W + PAR;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ss_n = 1'b1;
  logic               mosi = 1'b0;
  logic               tx_valid = 1'b0;
  logic [DATA_W-1:0]  tx_data = '0;
  logic               miso, rx_valid, tx_ready, busy, frame_err;
  logic [FRAME_W-1:0] rx_data;

  spi_slave_pframe #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                 is_err;
    logic [FRAME_W-1:0] data;
    int                 cyc;
  } ev_t;

  ev_t evq[$];
  bit  txq[$];
  bit  tx_on = 1'b0;
  bit  mon_en = 1'b0;
  bit  model_seen = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT pulse must match the head of the event queue, and miso must carry the
  // queued read bits right after a handshake and be 0 otherwise.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (rx_valid && frame_err) check("pulse_exclusive", 32'(rx_valid && frame_err), 0);
      if (rx_valid || frame_err) begin
        if (evq.size() == 0) begin
          check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 0);
        end else begin
          e = evq.pop_front();
          check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          check("pulse_cycle", cyc, e.cyc);
          if (!e.is_err) check("rx_data", 32'(rx_data), 32'(e.data));
        end
      end
      if (tx_on && txq.size() != 0) begin
        check("miso_bit", 32'(miso), 32'(txq.pop_front()));
      end else begin
        tx_on = 1'b0;
        check("miso_idle", 32'(miso), 0);
      end
      if (tx_valid && tx_ready) tx_on = 1'b1;
    end
  end

  task automatic edge_drive(input logic s, input logic m);
    ss_n = s;
    mosi = m;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input bit is_err, input logic [FRAME_W-1:0] d);
    ev_t e;
    e.is_err = is_err;
    e.data   = d;
    e.cyc    = cyc;
    evq.push_back(e);
  endtask

  task automatic end_frame_expect_idle();
    check("busy_after_deselect", 32'(busy), 0);
    repeat ($urandom_range(0, 2)) edge_drive(1'b1, 1'b0);
  endtask

  // One full SPI transaction. abort_at: payload bits sent before ss_n rises (-1: none).
  // tx_abort: TX edges before ss_n rises (-1: none). rst_at: TX edges before reset (-1: none).
  task automatic do_frame(input bit sel, input logic [FRAME_W-1:0] fr, input int abort_at,
                          input bit bad_par, input int tx_abort, input logic [DATA_W-1:0] txd,
                          input int rst_at);
    bit par_bit, ok, want_tx;
    int w, nbits;
    logic [TX_LEN-1:0] txw;
    par_bit = ~(^fr) ^ bad_par;
    edge_drive(1'b0, 1'b0);
    check("busy_high", 32'(busy), 1);
    edge_drive(1'b0, sel);
    for (int i = 0; i < RX_LEN; i++) begin
      if (i == abort_at) begin
        edge_drive(1'b1, 1'b0);
        push_ev(1'b1, '0);
        end_frame_expect_idle();
        return;
      end
      edge_drive(1'b0, (i < FRAME_W) ? fr[FRAME_W-1-i] : par_bit);
    end
    ok = (fr[FRAME_W-1] == sel) && !((PAR == 1) && bad_par);
    push_ev(!ok, fr);
    want_tx = ok && sel && model_seen;
    if (ok && sel && !model_seen) model_seen = 1'b1;
    if (!want_tx) begin
      repeat (2) begin
        check("tx_ready_low", 32'(tx_ready), 0);
        edge_drive(1'b0, 1'b0);
      end
      edge_drive(1'b1, 1'b0);
      end_frame_expect_idle();
      return;
    end
    w = 0;
    while (!tx_ready && w < 3) begin
      edge_drive(1'b0, 1'b0);
      w++;
    end
    check("tx_ready_high", 32'(tx_ready), 1);
    if (!tx_ready) begin
      edge_drive(1'b1, 1'b0);
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      edge_drive(1'b0, 1'b0);
      check("tx_ready_hold", 32'(tx_ready), 1);
    end
    txw = (PAR == 1) ? {txd, ~(^txd)} : TX_LEN'(txd);
    nbits = (tx_abort >= 0) ? tx_abort + 1 : TX_LEN;
    for (int k = 0; k < nbits; k++) txq.push_back(txw[TX_LEN-1-k]);
    tx_valid = 1'b1;
    tx_data  = txd;
    edge_drive(1'b0, 1'b0);
    tx_valid = 1'b0;
    tx_data  = DATA_W'($urandom);
    if (rst_at >= 0) begin
      repeat (rst_at) edge_drive(1'b0, 1'b0);
      rst = 1'b1;
      edge_drive(1'b0, 1'b0);
      txq.delete();
      model_seen = 1'b0;
      check("rst_miso", 32'(miso), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_tx_ready", 32'(tx_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      rst = 1'b0;
      edge_drive(1'b1, 1'b0);
    end else if (tx_abort >= 0) begin
      repeat (tx_abort) edge_drive(1'b0, 1'b0);
      edge_drive(1'b1, 1'b0);
      push_ev(1'b1, '0);
      end_frame_expect_idle();
    end else begin
      repeat (TX_LEN) edge_drive(1'b0, 1'b0);
      model_seen = 1'b0;
      edge_drive(1'b0, 1'b0);
      edge_drive(1'b1, 1'b0);
      end_frame_expect_idle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit                 sel;
    logic [FRAME_W-1:0] fr;
    int                 ab, tab;
    bit                 bp;
    rst = 1'b1;
    repeat (2) edge_drive(1'b1, 1'b0);
    check("reset_miso", 32'(miso), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_tx_ready", 32'(tx_ready), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    edge_drive(1'b1, 1'b0);

    do_frame(1'b0, 10'h0A5, -1, 1'b0, -1, 8'h00, -1);  // write-addr
    do_frame(1'b1, 10'h213, -1, 1'b0, -1, 8'h00, -1);  // read-addr
    do_frame(1'b1, 10'h300, -1, 1'b0, -1, 8'hC3, -1);  // read-data, miso 11000011
    do_frame(1'b0, 10'h0A5, 7, 1'b0, -1, 8'h00, -1);   // abort after 5 payload bits
    do_frame(1'b0, 10'h3A5, -1, 1'b0, -1, 8'h00, -1);  // selector/cmd mismatch
    do_frame(1'b1, 10'h2F0, -1, 1'b0, -1, 8'h00, -1);
    do_frame(1'b1, 10'h35A, -1, 1'b0, -1, 8'h96, 3);   // reset during TX
    do_frame(1'b1, 10'h300, -1, 1'b0, -1, 8'h00, -1);  // must land in read-addr
    do_frame(1'b1, 10'h3FF, -1, 1'b0, -1, 8'h5A, -1);
`ifdef SPI_SLAVE_PARITY_EN
    do_frame(1'b0, 10'h0A5, -1, 1'b1, -1, 8'h00, -1);
    do_frame(1'b0, 10'h0A5, -1, 1'b0, -1, 8'h00, -1);
`endif

    for (int t = 0; t < 60; t++) begin
      sel = 1'(($urandom) % 2);
      fr  = FRAME_W'($urandom);
      if ($urandom % 5 != 0) fr[FRAME_W-1] = sel;
      ab  = ($urandom % 5 == 0) ? int'($urandom_range(0, RX_LEN - 1)) : -1;
      bp  = (PAR == 1) && ($urandom % 5 == 0);
      tab = ($urandom % 5 == 0) ? int'($urandom_range(0, TX_LEN - 1)) : -1;
      do_frame(sel, fr, ab, bp, tab, DATA_W'($urandom), -1);
    end

    repeat (4) edge_drive(1'b1, 1'b0);
    check("events_drained", evq.size(), 0);
    check("tx_bits_drained", txq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
